// File: rtl/truth_table_sweeper_pkg.sv
// Shared types and width helpers for the truth-table sweeper.
// The table and count widths are derived from N_IN.
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a full truth table for an n-input function.
    function automatic int tt_w(input int n);
        return 1 << n;
    endfunction

    // Counts need one extra bit so that 2^n itself fits.
    function automatic int cnt_w(input int n);
        return n + 1;
    endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Bus between the sweeper and its driver.
// start/abort are single-cycle-sampled requests; done is a one-cycle pulse.
interface truth_table_sweeper_if
    import sweeper_pkg::*;
#(
    parameter int N_IN = 4
);
    logic                       start;
    logic                       abort;
    logic [tt_w(N_IN)-1:0]      expected;
    logic                       y_in;
    logic [N_IN-1:0]            x_out;
    logic                       busy;
    logic                       done;
    logic                       result_valid;
    logic [tt_w(N_IN)-1:0]      truth_table;
    logic [cnt_w(N_IN)-1:0]     ones_count;
    logic [cnt_w(N_IN)-1:0]     mismatch_count;
    logic                       any_mismatch;
    logic [N_IN-1:0]            first_mismatch;
    state_t                     state_dbg;

    modport master (
        output start, abort, expected, y_in,
        input  x_out, busy, done, result_valid, truth_table, ones_count,
               mismatch_count, any_mismatch, first_mismatch, state_dbg
    );

    modport slave (
        input  start, abort, expected, y_in,
        output x_out, busy, done, result_valid, truth_table, ones_count,
               mismatch_count, any_mismatch, first_mismatch, state_dbg
    );
endinterface

// File: rtl/truth_table_sweeper_sweep_ctr.sv
// Vector counter plus per-vector settle down-counter.
// sample_en marks the last settle cycle of the current vector.
module sweep_ctr
    import sweeper_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            advance,
    output logic [N_IN-1:0] x,
    output logic            sample_en,
    output logic            last_vec
);
    localparam logic [3:0] SETTLE_L = 4'(SETTLE);

    logic [N_IN-1:0] x_q;
    logic [3:0]      settle_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q      <= '0;
            settle_q <= '0;
        end else if (clear) begin
            x_q      <= '0;
            settle_q <= SETTLE_L;
        end else if (advance) begin
            if (settle_q != 4'd0) begin
                settle_q <= settle_q - 4'd1;
            end else if (!last_vec) begin
                // The last vector is never incremented past, so x_out holds.
                x_q      <= x_q + N_IN'(1);
                settle_q <= SETTLE_L;
            end
        end
    end

    assign x         = x_q;
    assign last_vec  = &x_q;
    assign sample_en = advance && (settle_q == 4'd0);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every input vector, samples y_in,
// and compares the captured table against a latched golden table.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int SETTLE = 1
) (
    input logic                   clk,
    input logic                   rst,
    truth_table_sweeper_if.slave  bus
);
    localparam int TT_W  = tt_w(N_IN);
    localparam int CNT_W = cnt_w(N_IN);

    state_t state_q, state_d;

    logic            accept;
    logic            advance;
    logic            sample_en;
    logic            last_vec;
    logic [N_IN-1:0] x;

    logic [TT_W-1:0]  tt_q;
    logic [TT_W-1:0]  exp_q;
    logic [CNT_W-1:0] ones_q;
    logic [CNT_W-1:0] mism_q;
    logic             any_q;
    logic [N_IN-1:0]  first_q;
    logic             rv_q;
    logic             miss;

    assign accept  = bus.start && (state_q != RUN);
    // Abort wins over the sample cycle: the aborted vector is not captured.
    assign advance = (state_q == RUN) && !bus.abort;
    assign miss    = bus.y_in != exp_q[x];

    sweep_ctr #(.N_IN(N_IN), .SETTLE(SETTLE)) u_ctr (
        .clk       (clk),
        .rst       (rst),
        .clear     (accept),
        .advance   (advance),
        .x         (x),
        .sample_en (sample_en),
        .last_vec  (last_vec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN: begin
                if (bus.abort)                  state_d = IDLE;
                else if (sample_en && last_vec) state_d = DONE;
            end
            DONE:    state_d = bus.start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        bus.state_dbg = state_q;
        case (state_q)
            RUN:     bus.busy = 1'b1;
            DONE:    bus.done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tt_q    <= '0;
            exp_q   <= '0;
            ones_q  <= '0;
            mism_q  <= '0;
            any_q   <= 1'b0;
            first_q <= '0;
            rv_q    <= 1'b0;
        end else if (accept) begin
            tt_q    <= '0;
            exp_q   <= bus.expected;
            ones_q  <= '0;
            mism_q  <= '0;
            any_q   <= 1'b0;
            first_q <= '0;
            rv_q    <= 1'b0;
        end else if (sample_en) begin
            tt_q[x] <= bus.y_in;
            ones_q  <= ones_q + CNT_W'(bus.y_in);
            if (miss) begin
                mism_q <= mism_q + CNT_W'(1);
                if (!any_q) begin
                    first_q <= x;
                    any_q   <= 1'b1;
                end
            end
            if (last_vec) rv_q <= 1'b1;
        end
    end

    assign bus.x_out          = x;
    assign bus.result_valid   = rv_q;
    assign bus.truth_table    = tt_q;
    assign bus.ones_count     = ones_q;
    assign bus.mismatch_count = mism_q;
    assign bus.any_mismatch   = any_q;
    assign bus.first_mismatch = first_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: a SETTLE=1 and a SETTLE=0 instance, random
// functions and golden tables checked against a vector-by-vector model.
module tb_truth_table_sweeper;
  import sweeper_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(4)) b1 ();
  truth_table_sweeper_if #(.N_IN(4)) b0 ();

  logic [15:0] fn1, fn0;
  assign b1.y_in = fn1[b1.x_out];
  assign b0.y_in = fn0[b0.x_out];

  truth_table_sweeper #(.N_IN(4), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  truth_table_sweeper #(.N_IN(4), .SETTLE(0)) dut0 (.clk(clk), .rst(rst), .bus(b0));

  int n_checks = 0;
  int n_fail = 0;

  // Reference: what a sweep of the first nvec vectors must leave behind.
  task automatic model(input logic [15:0] fn, input logic [15:0] exp, input int nvec,
                       output logic [15:0] tt, output int ones, output int mism,
                       output int first, output bit any);
    tt = '0; ones = 0; mism = 0; first = 0; any = 0;
    for (int i = 0; i < nvec; i++) begin
      tt[i] = fn[i];
      if (fn[i]) ones++;
      if (fn[i] != exp[i]) begin
        mism++;
        if (!any) begin first = i; any = 1; end
      end
    end
  endtask

  task automatic start1();
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
  endtask

  task automatic wait_done1(output int cyc);
    cyc = 0;
    while (!b1.done && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    n_checks++;
    if ({b1.x_out, b1.busy, b1.done, b1.result_valid, b1.truth_table, b1.ones_count,
         b1.mismatch_count, b1.any_mismatch, b1.first_mismatch} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: x=%h busy=%b done=%b rv=%b tt=%h ones=%0d mism=%0d any=%b first=%0d, required all 0",
               b1.x_out, b1.busy, b1.done, b1.result_valid, b1.truth_table, b1.ones_count,
               b1.mismatch_count, b1.any_mismatch, b1.first_mismatch);
    end
    n_checks++;
    if (b1.state_dbg !== IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d required %0d", b1.state_dbg, IDLE);
    end
  endtask

  // One full sweep; expected is disturbed mid-sweep to check it was latched.
  task automatic test_sweep(input logic [15:0] fn, input logic [15:0] exp, input string nm);
    logic [15:0] m_tt; int m_ones, m_mism, m_first; bit m_any; int cyc;
    model(fn, exp, 16, m_tt, m_ones, m_mism, m_first, m_any);
    fn1 = fn; b1.expected = exp;
    start1();
    n_checks++;
    if (b1.busy !== 1'b1) begin n_fail++; $display("FAIL %s busy_after_start: got %b required 1", nm, b1.busy); end
    b1.expected = ~exp;
    wait_done1(cyc);
    n_checks++;
    if (cyc != 32) begin n_fail++; $display("FAIL %s latency: got %0d required 32", nm, cyc); end
    n_checks++;
    if (b1.truth_table !== m_tt || b1.ones_count !== 5'(m_ones) || b1.mismatch_count !== 5'(m_mism) ||
        b1.first_mismatch !== 4'(m_first) || b1.any_mismatch !== m_any || b1.result_valid !== 1'b1 ||
        b1.x_out !== 4'hf) begin
      n_fail++;
      $display("FAIL %s results: tt=%h ones=%0d mism=%0d first=%0d any=%b rv=%b x=%h required tt=%h ones=%0d mism=%0d first=%0d any=%b rv=1 x=f",
               nm, b1.truth_table, b1.ones_count, b1.mismatch_count, b1.first_mismatch, b1.any_mismatch,
               b1.result_valid, b1.x_out, m_tt, m_ones, m_mism, m_first, m_any);
    end
    @(negedge clk);
    n_checks++;
    if (b1.done !== 1'b0 || b1.busy !== 1'b0 || b1.result_valid !== 1'b1 || b1.truth_table !== m_tt) begin
      n_fail++;
      $display("FAIL %s after_done: done=%b busy=%b rv=%b tt=%h required 0 0 1 %h",
               nm, b1.done, b1.busy, b1.result_valid, b1.truth_table, m_tt);
    end
  endtask

  task automatic test_golden();
    test_sweep(16'h6996, 16'h6996, "xor_match");
    n_checks++;
    if (b1.truth_table !== 16'h6996 || b1.ones_count !== 5'd8 || b1.mismatch_count !== 5'd0 || b1.any_mismatch !== 1'b0) begin
      n_fail++; $display("FAIL xor_literal: tt=%h ones=%0d mism=%0d any=%b required 6996 8 0 0",
                         b1.truth_table, b1.ones_count, b1.mismatch_count, b1.any_mismatch);
    end
    test_sweep(16'h6996, 16'h6997, "xor_one_off");
    n_checks++;
    if (b1.mismatch_count !== 5'd1 || b1.first_mismatch !== 4'd0 || b1.any_mismatch !== 1'b1) begin
      n_fail++; $display("FAIL one_off_literal: mism=%0d first=%0d any=%b required 1 0 1",
                         b1.mismatch_count, b1.first_mismatch, b1.any_mismatch);
    end
    test_sweep(16'h6996, 16'h0000, "xor_vs_zero");
    n_checks++;
    if (b1.mismatch_count !== 5'd8 || b1.first_mismatch !== 4'd1) begin
      n_fail++; $display("FAIL zero_literal: mism=%0d first=%0d required 8 1", b1.mismatch_count, b1.first_mismatch);
    end
    test_sweep(16'hffff, 16'h0000, "all_ones_count_16");
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      logic [15:0] fn, ex;
      fn = 16'($urandom);
      ex = (i % 2 == 0) ? 16'($urandom) : (fn ^ (16'h1 << $urandom_range(0, 15)));
      test_sweep(fn, ex, "random");
    end
  endtask

  task automatic test_settle0();
    int cyc;
    fn0 = 16'h8000; b0.expected = 16'h8000;
    b0.start = 1'b1;
    @(negedge clk);
    b0.start = 1'b0;
    cyc = 0;
    while (!b0.done && cyc < 300) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc != 16) begin n_fail++; $display("FAIL settle0_latency: got %0d required 16", cyc); end
    n_checks++;
    if (b0.truth_table !== 16'h8000 || b0.ones_count !== 5'd1 || b0.mismatch_count !== 5'd0 || b0.result_valid !== 1'b1) begin
      n_fail++; $display("FAIL settle0_results: tt=%h ones=%0d mism=%0d rv=%b required 8000 1 0 1",
                         b0.truth_table, b0.ones_count, b0.mismatch_count, b0.result_valid);
    end
  endtask

  // Abort raised during RUN cycle k; vectors finished before it stay visible.
  task automatic test_abort(input int k);
    logic [15:0] fn, ex, m_tt; int m_ones, m_mism, m_first, nvec; bit m_any; bit saw_done;
    fn = 16'($urandom); ex = 16'($urandom);
    nvec = (k - 1) / 2;
    model(fn, ex, nvec, m_tt, m_ones, m_mism, m_first, m_any);
    fn1 = fn; b1.expected = ex;
    start1();
    repeat (k - 1) @(negedge clk);
    b1.abort = 1'b1;
    @(negedge clk);
    b1.abort = 1'b0;
    n_checks++;
    if (b1.busy !== 1'b0 || b1.done !== 1'b0 || b1.result_valid !== 1'b0) begin
      n_fail++; $display("FAIL abort_k%0d_flags: busy=%b done=%b rv=%b required 0 0 0", k, b1.busy, b1.done, b1.result_valid);
    end
    n_checks++;
    if (b1.truth_table !== m_tt || b1.ones_count !== 5'(m_ones) || b1.mismatch_count !== 5'(m_mism) ||
        b1.first_mismatch !== 4'(m_first) || b1.any_mismatch !== m_any || b1.x_out !== 4'(nvec)) begin
      n_fail++;
      $display("FAIL abort_k%0d_partial: tt=%h ones=%0d mism=%0d first=%0d any=%b x=%0d required %h %0d %0d %0d %b %0d",
               k, b1.truth_table, b1.ones_count, b1.mismatch_count, b1.first_mismatch, b1.any_mismatch, b1.x_out,
               m_tt, m_ones, m_mism, m_first, m_any, nvec);
    end
    saw_done = 0;
    repeat (40) begin @(negedge clk); if (b1.done || b1.busy) saw_done = 1; end
    n_checks++;
    if (saw_done) begin n_fail++; $display("FAIL abort_k%0d_quiet: saw done/busy after abort, required none", k); end
  endtask

  task automatic test_abort_idle();
    int cyc;
    fn1 = 16'h6996; b1.expected = 16'h6996;
    b1.start = 1'b1; b1.abort = 1'b1;
    @(negedge clk);
    b1.start = 1'b0; b1.abort = 1'b0;
    wait_done1(cyc);
    n_checks++;
    if (cyc != 32 || b1.mismatch_count !== 5'd0 || b1.truth_table !== 16'h6996) begin
      n_fail++; $display("FAIL abort_in_idle: cyc=%0d mism=%0d tt=%h required 32 0 6996", cyc, b1.mismatch_count, b1.truth_table);
    end
    @(negedge clk);
  endtask

  task automatic test_start_busy();
    int cyc;
    fn1 = 16'h8000; b1.expected = 16'h8000;
    start1();
    repeat (5) @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    cyc = 6;
    while (!b1.done && cyc < 300) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc != 32 || b1.truth_table !== 16'h8000) begin
      n_fail++; $display("FAIL start_while_busy: cyc=%0d tt=%h required 32 8000", cyc, b1.truth_table);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int guard;
    fn1 = 16'hffff; b1.expected = 16'h0000;
    start1();
    guard = 0;
    while (b1.x_out != 4'd5 && guard < 100) begin @(negedge clk); guard++; end
    n_checks++;
    if (guard >= 100) begin n_fail++; $display("FAIL reset_mid_reach: x=%0d required 5", b1.x_out); end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({b1.x_out, b1.busy, b1.done, b1.result_valid, b1.truth_table, b1.ones_count,
         b1.mismatch_count, b1.any_mismatch, b1.first_mismatch} !== '0 || b1.state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_async: x=%0d busy=%b rv=%b tt=%h ones=%0d mism=%0d any=%b first=%0d, required all 0",
               b1.x_out, b1.busy, b1.result_valid, b1.truth_table, b1.ones_count,
               b1.mismatch_count, b1.any_mismatch, b1.first_mismatch);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] m_tt; int m_ones, m_mism, m_first; bit m_any; int cyc;
    fn1 = 16'h6996; b1.expected = 16'h6996;
    start1();
    wait_done1(cyc);
    n_checks++;
    if (cyc != 32) begin n_fail++; $display("FAIL b2b_first_latency: got %0d required 32", cyc); end
    fn1 = 16'($urandom); b1.expected = 16'($urandom);
    model(fn1, b1.expected, 16, m_tt, m_ones, m_mism, m_first, m_any);
    start1();
    n_checks++;
    if (b1.busy !== 1'b1 || b1.result_valid !== 1'b0 || b1.truth_table !== '0 || b1.ones_count !== '0 ||
        b1.mismatch_count !== '0 || b1.any_mismatch !== 1'b0 || b1.first_mismatch !== '0) begin
      n_fail++;
      $display("FAIL b2b_restart_clear: busy=%b rv=%b tt=%h ones=%0d mism=%0d any=%b first=%0d required 1 0 0 0 0 0 0",
               b1.busy, b1.result_valid, b1.truth_table, b1.ones_count, b1.mismatch_count, b1.any_mismatch, b1.first_mismatch);
    end
    wait_done1(cyc);
    n_checks++;
    if (cyc != 32 || b1.truth_table !== m_tt || b1.mismatch_count !== 5'(m_mism) || b1.first_mismatch !== 4'(m_first)) begin
      n_fail++;
      $display("FAIL b2b_second: cyc=%0d tt=%h mism=%0d first=%0d required 32 %h %0d %0d",
               cyc, b1.truth_table, b1.mismatch_count, b1.first_mismatch, m_tt, m_mism, m_first);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    b1.start = 1'b0; b1.abort = 1'b0; b1.expected = '0;
    b0.start = 1'b0; b0.abort = 1'b0; b0.expected = '0;
    fn1 = '0; fn0 = '0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_golden();
    test_random();
    test_settle0();
    test_abort(10);
    test_sweep(16'h6996, 16'h6996, "clean_after_abort");
    for (int i = 0; i < 3; i++) test_abort($urandom_range(2, 31));
    test_abort_idle();
    test_start_busy();
    test_reset_mid();
    test_sweep(16'h1234, 16'h1235, "after_reset");
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Hardware successor to the exhaustive stimulus benches used for combinational lab circuits.
- Walks all 2^N_IN input combinations of an externally attached N_IN-input combinational function and waits a programmable settle time per vector.
- Samples the function output on every vector and captures the full truth table.
- Compares the captured table against an expected table and reports minterm count, mismatch count and the first failing index, under a start/busy/done handshake.

Parameters:
- N_IN, 4, number of function inputs; legal range 1..8.
- SETTLE, 1, extra hold cycles per vector before sampling; legal range 0..15.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a sweep; accepted only in IDLE or DONE.
- abort  input  1  cancel a running sweep.
- expected  input  2^N_IN  golden truth table; bit i is the expected output for input vector i.
- y_in  input  1  output of the function under test.
- x_out  output  N_IN  input vector driven to the function under test.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- result_valid  output  1  result registers hold a complete sweep.
- truth_table  output  2^N_IN  captured table; bit i is y_in sampled for vector i.
- ones_count  output  N_IN+1  number of 1 bits in truth_table.
- mismatch_count  output  N_IN+1  number of indices where truth_table differs from expected.
- any_mismatch  output  1  mismatch_count != 0.
- first_mismatch  output  N_IN  lowest failing index; 0 when there is no mismatch.

Behaviour:
- Reset, asynchronous: state=IDLE and every output is 0 (x_out, busy, done, result_valid, truth_table, counts, any_mismatch, first_mismatch). The captured expected register is also cleared. This holds when reset is asserted mid-sweep.
- FSM has three states: IDLE, RUN, DONE.
- IDLE or DONE with start=1: on the next edge, clear truth_table, both counts, any_mismatch, first_mismatch and result_valid; latch expected; set x_out=0, settle counter=SETTLE, state=RUN, busy=1.
- RUN, settle counter >0: hold x_out and decrement the counter.
- RUN, settle counter ==0 (sample cycle):
  - write y_in into truth_table[x_out];
  - ones_count += y_in;
  - if y_in != expected_q[x_out]: mismatch_count++; if it is the first mismatch, set first_mismatch=x_out and any_mismatch=1.
  - if x_out == 2^N_IN-1: state=DONE, busy=0, done=1, result_valid=1.
  - otherwise: x_out++ and reload the settle counter with SETTLE.
- Latency: each vector occupies SETTLE+1 cycles. done rises exactly 2^N_IN*(SETTLE+1) cycles after the start-accept edge. With N_IN=4 and SETTLE=1 that is 32 cycles.
- DONE lasts one cycle (done=1), then returns to IDLE unless start is high. Results and x_out stay held until the next accepted start.
- start while busy=1 is ignored, with no effect.
- abort in RUN: next edge goes to IDLE with busy=0. done is not pulsed, result_valid stays 0, and partial results remain visible.
- abort outside RUN is ignored.
- start and abort high together in RUN: abort wins.
- x_out does not wrap. The final index is detected explicitly, so the counter never rolls over inside a sweep.
- Arithmetic: counts are N_IN+1 bits wide, so a value of 2^N_IN fits with no overflow. Expected is sampled only at start; later changes to it during a sweep have no effect.

Decomposition:
- Shared package sweeper_pkg holds the state enum (IDLE, RUN, DONE) and the width helpers TT_W=2^N_IN and CNT_W=N_IN+1.
- One sub-module, sweep_ctr: the vector counter plus the settle down-counter. It emits sample_en and last_vec and takes clear/advance controls.
- The top level holds the FSM, the capture, compare and count logic, and the outputs.

Test Plan:
- N_IN=4, SETTLE=1, y_in = XOR of x_out[3:0], expected=16'h6996, pulse start → done exactly 32 cycles after accept. Required: truth_table=16'h6996, ones_count=8, mismatch_count=0, any_mismatch=0, result_valid=1.
- Same function, expected=16'h6997 → mismatch_count=1, first_mismatch=0, any_mismatch=1. With expected=16'h0000: mismatch_count=8, first_mismatch=1.
- y_in = x_out[3]&x_out[2]&x_out[1]&x_out[0], SETTLE=0 → done 16 cycles after accept; truth_table=16'h8000, ones_count=1.
- Start, then assert abort on cycle 10 of RUN → busy=0 next cycle; done never pulses; result_valid=0. A new start then produces a clean, correct sweep.
- Assert rst asynchronously mid-sweep (x_out=5) → all outputs become 0 immediately, before the next clock edge. start while busy is ignored: done timing is unchanged.
- start held high through the DONE cycle → a second sweep begins immediately, result_valid drops and results are cleared, and the second done arrives 32 cycles later.
